// File: rtl/fetch_unit_if.sv
// fetch_unit_if: hazard-controller IF controls, I-cache request/response and decode head.
// Latency: none, wires only.
// Backpressure: ic_req_ready throttles requests; hc_dec_stall throttles the decode head.
interface fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  load_pc_we;
    logic [ADDR_WIDTH-1:0] load_pc_new_pc;
    logic                  hc_if_stall;
    logic                  hc_dec_stall;
    logic                  hc_dec_flush;
    logic                  ic_req_valid;
    logic [ADDR_WIDTH-1:0] ic_req_addr;
    logic                  ic_req_ready;
    logic                  ic_rsp_valid;
    logic [DATA_WIDTH-1:0] ic_rsp_data;
    logic                  dec_valid;
    logic [ADDR_WIDTH-1:0] dec_pc;
    logic [DATA_WIDTH-1:0] dec_instr;

    modport master (
        input  load_pc_we, load_pc_new_pc, hc_if_stall, hc_dec_stall, hc_dec_flush,
        input  ic_req_ready, ic_rsp_valid, ic_rsp_data,
        output ic_req_valid, ic_req_addr, dec_valid, dec_pc, dec_instr
    );

    modport slave (
        output load_pc_we, load_pc_new_pc, hc_if_stall, hc_dec_stall, hc_dec_flush,
        output ic_req_ready, ic_rsp_valid, ic_rsp_data,
        input  ic_req_valid, ic_req_addr, dec_valid, dec_pc, dec_instr
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, keeps one I-cache request in flight, buffers words for decode.
// Latency: redirect at t -> request at t+1 -> dec_valid at t+3; steady stream is one word per 2 cycles.
// Backpressure: buffer slot reserved at issue; no request while full or hc_if_stall. FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit #(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          FB_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_redirects,
    output logic [31:0]  perf_squashed,
    output logic [31:0]  perf_starve
`endif
);
    localparam int unsigned PTR_W = $clog2(FB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FB_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fb_entry_t;

    logic [1:0]            state, state_n;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  outstanding;
    logic                  drop;
    fb_entry_t             fb_mem [FB_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count, count_n;
    logic                  redirect, accept, rsp_take, push, pop;

    assign redirect = bus.load_pc_we;

    // A request marked for drop answers this cycle, so it does not block the next issue.
    assign bus.ic_req_valid = (state == S_RUN) && (!outstanding || drop) &&
                              (count < FULL_CNT) && !bus.hc_if_stall;
    assign bus.ic_req_addr  = fetch_pc;

    assign accept   = bus.ic_req_valid && bus.ic_req_ready;
    assign rsp_take = outstanding && bus.ic_rsp_valid;
    assign push     = rsp_take && !drop && !redirect;
    assign pop      = bus.dec_valid && (!bus.hc_dec_stall || bus.hc_dec_flush) && !redirect;

    assign bus.dec_valid = (count != '0);
    assign bus.dec_pc    = bus.dec_valid ? fb_mem[rd_ptr].pc    : '0;
    assign bus.dec_instr = bus.dec_valid ? fb_mem[rd_ptr].instr : '0;

    always_comb begin
        count_n = count;
        if (redirect)
            count_n = '0;
        else if (push && !pop)
            count_n = count + CNT_W'(1);
        else if (pop && !push)
            count_n = count - CNT_W'(1);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = S_RUN;
            S_RUN:   if (count_n == FULL_CNT) state_n = S_FULL;
            S_FULL:  if (count_n < FULL_CNT)  state_n = S_RUN;
            default: state_n = S_IDLE;
        endcase
        if (redirect)
            state_n = S_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (accept) begin
                outstanding <= 1'b1;
                req_pc      <= fetch_pc;
            end else if (rsp_take) begin
                outstanding <= 1'b0;
            end
            // Whatever is still in flight across a redirect belongs to the old stream.
            if (redirect)
                drop <= accept || (outstanding && !bus.ic_rsp_valid);
            else if (accept || rsp_take)
                drop <= 1'b0;
            if (redirect) begin
                fetch_pc <= bus.load_pc_new_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fb_mem[wr_ptr] <= '{pc: req_pc, instr: bus.ic_rsp_data};
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W:0] squash_inc;
    assign squash_inc = (redirect ? {1'b0, count} : '0) +
                        {{CNT_W{1'b0}}, (rsp_take && (drop || redirect))};

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_redirects <= '0;
            perf_squashed  <= '0;
            perf_starve    <= '0;
        end else begin
            perf_redirects <= sat_add(perf_redirects, 32'(redirect));
            perf_squashed  <= sat_add(perf_squashed, 32'(squash_inc));
            perf_starve    <= sat_add(perf_starve, 32'(!bus.dec_valid));
        end
    end
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that consumes the hazard controller's IF-side outputs: the load_pc redirect, and the i2i/i2d stall and flush controls. It owns the fetch PC and issues word requests to the I-cache with at most one request outstanding. Returned instructions are buffered in a small FIFO that feeds decode. Redirects squash both the buffered and the in-flight instructions.

Parameters:
ADDR_WIDTH, 32, width of PC and cache address
DATA_WIDTH, 32, instruction width
FB_DEPTH, 4, fetch buffer entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
load_pc_we  in  1  redirect request
load_pc_new_pc  in  ADDR_WIDTH  redirect target (word aligned)
hc_if_stall  in  1  i2i stall: hold fetch PC, issue no new request
hc_dec_stall  in  1  i2d stall: decode does not consume this cycle
hc_dec_flush  in  1  i2d flush: discard the current FIFO head
ic_req_valid  out  1  cache request valid
ic_req_addr  out  ADDR_WIDTH  cache request address
ic_req_ready  in  1  cache accepts request (low during miss)
ic_rsp_valid  in  1  response, exactly 1 cycle after an accepted request
ic_rsp_data  in  DATA_WIDTH  instruction
dec_valid  out  1  FIFO head valid
dec_pc  out  ADDR_WIDTH  head PC
dec_instr  out  DATA_WIDTH  head instruction

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC; FIFO empty; count=0; no outstanding request; drop flag clear; state=S_IDLE. Outputs: ic_req_valid=0, ic_req_addr=RESET_PC, dec_valid=0, dec_pc=0, dec_instr=0.
- FSM:
  - S_IDLE: one cycle after reset release, then S_RUN.
  - S_RUN: ic_req_valid=1 when no request is outstanding, the FIFO has a free slot counting the in-flight entry, and hc_if_stall=0. On accept (valid&ready): outstanding=1, fetch_pc+=4, state stays S_RUN. If count==FB_DEPTH, go to S_FULL.
  - S_FULL: no requests. Return to S_RUN when count<FB_DEPTH.
- Response: when outstanding & ic_rsp_valid, push {req_pc, ic_rsp_data} unless the drop flag is set; in both cases clear outstanding and clear drop.
- Decode consume: pop the head when dec_valid & (~hc_dec_stall | hc_dec_flush). A flush pops regardless of stall.
- Redirect (load_pc_we=1), highest priority in its cycle:
  - FIFO cleared, count=0, fetch_pc=load_pc_new_pc.
  - If a request is outstanding or accepted this cycle, set drop.
  - The same-cycle ic_req is still presented at the old PC. The redirect takes effect at the next edge; the new PC is requested from cycle+1.
  - A response arriving in the redirect cycle is discarded. Pops in that cycle are irrelevant.
  - State returns to S_RUN.
- Push and pop in the same cycle: count unchanged. Push to a full FIFO cannot happen because credit is reserved at issue.
- Pointers are log2(FB_DEPTH) bits and wrap naturally. count is log2(FB_DEPTH)+1 bits.
- PC arithmetic is modulo 2^ADDR_WIDTH; 0xFFFF_FFFC+4 wraps to 0.
- hc_if_stall blocks only new requests. A response to an already-accepted request is still accepted.
- Latency: redirect at cycle t → request at new PC in t+1 (ready permitting) → dec_valid at t+3 (registered FIFO output).

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_redirects[31:0] (+1 per load_pc_we cycle), perf_squashed[31:0] (+1 per discarded response or flushed-by-redirect valid entry) and perf_starve[31:0] (+1 per cycle with dec_valid=0 and rst=0). All reset to 0 and saturate at 0xFFFF_FFFF.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset stream: ic_req_ready=1, hc_* =0 → requests at 0x0,0x4,0x8,... one every 2 cycles; dec_pc follows the same sequence; ic_req_valid=0 in the first cycle after reset release.
- Back-pressure: hc_dec_stall=1 for 20 cycles → exactly 4 instructions (0x0–0xC) buffered, ic_req_valid=0, state S_FULL. Release stall → 0x10 fetched next, no gaps or duplicates in dec_pc.
- Redirect in flight: request 0x8 accepted at t, load_pc_we=1 with new_pc 0x400 at t → response for 0x8 dropped, FIFO empty, next request 0x400, dec_pc=0x400 at t+3.
- Flush under stall: head=0x4, hc_dec_stall=1 and hc_dec_flush=1 → 0x4 popped, dec_pc=0x8 next cycle.
- Miss: ic_req_ready=0 for 10 cycles with addr 0x20 → ic_req_addr held at 0x20, no push. Ready=1 → single 0x20 entry.
- Async reset mid-operation with 3 buffered entries and one outstanding → immediately dec_valid=0, ic_req_valid=0. After release, fetch restarts at RESET_PC and the late ic_rsp_valid is ignored.
